// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the timer control sequencer.
//   state_e  - FSM state encoding, also driven out on the 3-bit state port
//   mode_e   - selected timing function
//   K_*      - bit positions of the used keys on the 12-bit keystroke bus
package timer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  typedef enum logic {
    ModeStopwatch = 1'b0,
    ModeCountdown = 1'b1
  } mode_e;

  localparam int unsigned K_SW    = 1;
  localparam int unsigned K_CD    = 3;
  localparam int unsigned K_SET   = 5;
  localparam int unsigned K_RUN   = 7;
  localparam int unsigned K_START = 8;
  localparam int unsigned K_CLR   = 9;

  localparam int unsigned NUM_KEYS = 6;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser followed by a consecutive-sample debouncer.
//   clk_raw  in  system clock
//   rst_n    in  asynchronous active-low reset
//   key_raw  in  raw key level, asynchronous to clk_raw
//   level    out debounced key level
//   rise     out one-cycle strobe in the cycle after level goes 0->1
module key_debounce #(
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic clk_raw,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  logic       sync1_q;
  logic       sync2_q;
  logic       level_q;
  logic       level_prev_q;
  logic [3:0] cnt_q;

  // cnt_q counts synchronised samples that differ from the accepted level; the
  // level flips on the sample after DB_CYCLES differing ones, so a pulse must
  // last DB_CYCLES+1 cycles to be accepted.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      sync1_q      <= key_raw;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      if (sync2_q == level_q) begin
        cnt_q <= 4'd0;
      end else if (cnt_q == 4'(DB_CYCLES)) begin
        level_q <= sync2_q;
        cnt_q   <= 4'd0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: keystroke-driven sequencer for the timing datapath.
//   clk_raw   in  system clock
//   rst_n     in  asynchronous active-low reset
//   keystroke in  raw 12-bit key bus (asynchronous)
//   tick      in  one-cycle time-base strobe
//   zero      in  datapath count equals 0
//   cnt_en    out counter advances this cycle (combinational)
//   up_dn     out 1 = count up (stopwatch), 0 = count down
//   cnt_clr   out one-cycle counter clear pulse
//   set_inc   out one-cycle increment-set-digit pulse
//   alarm     out countdown expired indicator
//   state     out current FSM state
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 3,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic        clk_raw,
  input  logic        rst_n,
  input  logic [11:0] keystroke,
  input  logic        tick,
  input  logic        zero,
  output logic        cnt_en,
  output logic        up_dn,
  output logic        cnt_clr,
  output logic        set_inc,
  output logic        alarm,
  output logic [2:0]  state
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] key_rise;

  assign key_raw = {keystroke[K_CLR], keystroke[K_START], keystroke[K_RUN],
                    keystroke[K_SET], keystroke[K_CD], keystroke[K_SW]};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_key_debounce (
      .clk_raw(clk_raw),
      .rst_n  (rst_n),
      .key_raw(key_raw[i]),
      .level  (key_lvl[i]),
      .rise   (key_rise[i])
    );
  end

  logic sw_lvl, cd_lvl, set_lvl, run_lvl, start_e, clr_e;
  assign sw_lvl  = key_lvl[0];
  assign cd_lvl  = key_lvl[1];
  assign set_lvl = key_lvl[2];
  assign run_lvl = key_lvl[3];
  assign start_e = key_rise[4];
  assign clr_e   = key_rise[5];

  logic unused_sig;
  assign unused_sig = ^{keystroke[0], keystroke[2], keystroke[4], keystroke[6],
                        keystroke[11:10], key_rise[3:0], key_lvl[5:4]};

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic       clr_q, clr_d;
  logic       inc_q, inc_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= ModeStopwatch;
      clr_q       <= 1'b0;
      inc_q       <= 1'b0;
      alarm_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      clr_q       <= clr_d;
      inc_q       <= inc_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  // Mode keys are only honoured in IDLE; stopwatch wins if both are held.
  always_comb begin
    mode_d = mode_q;
    if (state_q == StIdle) begin
      if (sw_lvl) begin
        mode_d = ModeStopwatch;
      end else if (cd_lvl) begin
        mode_d = ModeCountdown;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_d       = 1'b0;
    inc_d       = 1'b0;
    alarm_cnt_d = alarm_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_e) begin
          clr_d = 1'b1;
        end else if (start_e && run_lvl) begin
          state_d = StRun;
        end else if (set_lvl && (mode_q == ModeCountdown)) begin
          state_d = StSet;
        end
      end
      StSet: begin
        if (clr_e) begin
          clr_d = 1'b1;
        end else if (start_e) begin
          inc_d = 1'b1;
        end
        if (!set_lvl) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (clr_e) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end else if (start_e) begin
          state_d = StPause;
        end else if ((mode_q == ModeCountdown) && zero && tick) begin
          state_d = StDone;
        end else if (!run_lvl) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (clr_e) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end else if (start_e && run_lvl) begin
          state_d = StRun;
        end
      end
      StDone: begin
        // Count is already 0 here, so leaving DONE issues no clear.
        if (start_e || clr_e) begin
          state_d = StIdle;
        end else if (tick) begin
          if (alarm_cnt_q == 8'(ALARM_TICKS - 1)) begin
            state_d = StIdle;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != StDone) begin
      alarm_cnt_d = 8'd0;
    end
  end

  // Suppress the count-down step at zero so the counter never wraps below 0.
  assign cnt_en  = tick && (state_q == StRun) && !((mode_q == ModeCountdown) && zero);
  assign up_dn   = (mode_q == ModeStopwatch);
  assign cnt_clr = clr_q;
  assign set_inc = inc_q;
  assign alarm   = (state_q == StDone);
  assign state   = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int DB = 3;

  logic        clk_raw;
  logic        rst_n;
  logic [11:0] keystroke;
  logic        tick;
  logic        zero;
  logic        cnt_en;
  logic        up_dn;
  logic        cnt_clr;
  logic        set_inc;
  logic        alarm;
  logic [2:0]  state;

  timer_ctrl #(
    .DB_CYCLES  (DB),
    .ALARM_TICKS(10)
  ) dut (
    .clk_raw  (clk_raw),
    .rst_n    (rst_n),
    .keystroke(keystroke),
    .tick     (tick),
    .zero     (zero),
    .cnt_en   (cnt_en),
    .up_dn    (up_dn),
    .cnt_clr  (cnt_clr),
    .set_inc  (set_inc),
    .alarm    (alarm),
    .state    (state)
  );

  initial begin
    clk_raw = 1'b0;
    forever #5 clk_raw = ~clk_raw;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk_raw);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       clr;
    logic       inc;
    logic       alm;
    logic       up;
    int         at;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input string name, input logic [2:0] st, input logic clr,
                      input logic inc, input logic alm, input logic up, input int at);
    exp_t e;
    e.name = name; e.st = st; e.clr = clr; e.inc = inc; e.alm = alm; e.up = up; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every state change or cnt_clr/set_inc pulse is an output event.
  initial begin
    logic [2:0] prev_st;
    exp_t e;
    prev_st = StIdle;
    forever begin
      @(negedge clk_raw);
      if ((state !== prev_st) || cnt_clr || set_inc) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: state=%0d clr=%0d inc=%0d at cyc %0d",
                   state, cnt_clr, set_inc, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((state !== e.st) || (cnt_clr !== e.clr) || (set_inc !== e.inc) ||
              (alarm !== e.alm) || (up_dn !== e.up) || ((e.at >= 0) && (cyc != e.at))) begin
            errors++;
            $display("FAIL %s: got state=%0d clr=%0d inc=%0d alarm=%0d up_dn=%0d cyc=%0d, expected state=%0d clr=%0d inc=%0d alarm=%0d up_dn=%0d cyc=%0d",
                     e.name, state, cnt_clr, set_inc, alarm, up_dn, cyc,
                     e.st, e.clr, e.inc, e.alm, e.up, e.at);
          end
        end
      end
      prev_st = state;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_raw);
  endtask

  task automatic pulse(input int idx, input int len);
    keystroke[idx] = 1'b1;
    cycles(len);
    keystroke[idx] = 1'b0;
  endtask

  task automatic do_ticks(input int n, output int en_cnt);
    en_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      #1;
      if (cnt_en) en_cnt++;
      @(negedge clk_raw);
      tick = 1'b0;
      @(negedge clk_raw);
    end
  endtask

  initial begin
    int n;
    int k;
    rst_n     = 1'b0;
    keystroke = 12'd0;
    tick      = 1'b0;
    zero      = 1'b0;
    cycles(3);
    check("reset_state", state, StIdle);
    check("reset_cnt_en", cnt_en, 0);
    check("reset_up_dn", up_dn, 1);
    check("reset_alarm", alarm, 0);
    check("reset_cnt_clr", cnt_clr, 0);
    check("reset_set_inc", set_inc, 0);
    rst_n = 1'b1;
    cycles(2);

    // Debounce: a 2-cycle start glitch is rejected, a 5-cycle pulse is taken.
    keystroke[K_SW]  = 1'b1;
    keystroke[K_RUN] = 1'b1;
    cycles(DB + 4);
    pulse(K_START, 2);
    cycles(10);
    check("glitch_rejected", state, StIdle);
    push("start_run_latency", StRun, 0, 0, 0, 1, cyc + 7);
    pulse(K_START, 5);
    cycles(4);

    // Stopwatch counting and pause.
    do_ticks(20, n);
    check("sw_cnt_en_count", n, 20);
    check("sw_up_dn", up_dn, 1);
    push("pause", StPause, 0, 0, 0, 1, -1);
    pulse(K_START, 5);
    cycles(4);
    do_ticks(5, n);
    check("pause_cnt_en_count", n, 0);

    // Clear beats start in RUN.
    push("resume", StRun, 0, 0, 0, 1, -1);
    pulse(K_START, 5);
    cycles(4);
    push("clr_priority", StIdle, 1, 0, 0, 1, -1);
    keystroke[K_START] = 1'b1;
    keystroke[K_CLR]   = 1'b1;
    cycles(5);
    keystroke[K_START] = 1'b0;
    keystroke[K_CLR]   = 1'b0;
    cycles(4);

    // Mode lock while running; mode follows keys again back in IDLE.
    push("run_sw", StRun, 0, 0, 0, 1, -1);
    pulse(K_START, 5);
    cycles(4);
    keystroke[K_SW] = 1'b0;
    keystroke[K_CD] = 1'b1;
    cycles(8);
    check("mode_locked_up_dn", up_dn, 1);
    check("mode_locked_state", state, StRun);
    push("clr_to_idle", StIdle, 1, 0, 0, 1, -1);
    pulse(K_CLR, 5);
    k = 0;
    while ((up_dn !== 1'b0) && (k < 3 + DB + 2)) begin
      cycles(1);
      k++;
    end
    check("mode_idle_up_dn", up_dn, 0);

    // Countdown set mode: three increments.
    push("enter_set", StSet, 0, 0, 0, 0, -1);
    keystroke[K_SET] = 1'b1;
    cycles(8);
    for (int i = 0; i < 3; i++) begin
      push("set_inc", StSet, 0, 1, 0, 0, -1);
      pulse(K_START, 5);
      cycles(4);
    end
    push("leave_set", StIdle, 0, 0, 0, 0, -1);
    keystroke[K_SET] = 1'b0;
    cycles(8);

    // Countdown run, expiry and alarm duration.
    push("run_cd", StRun, 0, 0, 0, 0, -1);
    pulse(K_START, 5);
    cycles(4);
    do_ticks(2, n);
    check("cd_cnt_en_count", n, 2);
    check("cd_up_dn", up_dn, 0);
    zero = 1'b1;
    push("expire", StDone, 0, 0, 1, 0, -1);
    do_ticks(1, n);
    check("cd_zero_no_cnt_en", n, 0);
    check("done_alarm", alarm, 1);
    do_ticks(9, n);
    check("done_holds_state", state, StDone);
    check("done_holds_alarm", alarm, 1);
    push("alarm_end", StIdle, 0, 0, 0, 0, -1);
    do_ticks(1, n);
    check("alarm_end_state", state, StIdle);
    check("alarm_end_alarm", alarm, 0);
    zero = 1'b0;

    // Asynchronous reset in RUN between clock edges.
    push("run_pre_reset", StRun, 0, 0, 0, 0, -1);
    pulse(K_START, 5);
    cycles(4);
    @(posedge clk_raw);
    #2;
    tick = 1'b1;
    push("async_reset", StIdle, 0, 0, 0, 1, -1);
    rst_n = 1'b0;
    #1;
    check("arst_state", state, StIdle);
    check("arst_cnt_en", cnt_en, 0);
    check("arst_alarm", alarm, 0);
    check("arst_up_dn", up_dn, 1);
    check("arst_cnt_clr", cnt_clr, 0);
    @(negedge clk_raw);
    tick      = 1'b0;
    keystroke = 12'd0;
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    check("events_consumed", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
